// File: rtl/dino_pkg.sv
// dino_pkg: shared obstacle encodings, scheduler states and default timing constants
package dino_pkg;

    localparam int DEF_GAP_W      = 8;
    localparam int DEF_GAP_MIN    = 48;
    localparam int DEF_GAP_STEP   = 8;
    localparam int DEF_SPEED_STEP = 4;
    localparam int DEF_GAP_FLOOR  = 24;
    localparam int DEF_MAX_ACTIVE = 3;
    localparam int DEF_BIRD_LEVEL = 3;

    typedef enum logic [1:0] {
        OBST_SMALL = 2'b00,
        OBST_LARGE = 2'b01,
        OBST_BIRD  = 2'b10,
        OBST_RSVD  = 2'b11
    } obst_t;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        DRAW,
        WAIT,
        HOLD,
        SPAWN
    } state_t;

    // 00/01 -> small cactus, 10 -> large cactus, 11 -> bird once birds are unlocked
    function automatic obst_t obst_map(input logic [1:0] sel, input logic bird_ok);
        return !sel[1] ? OBST_SMALL : (sel[0] && bird_ok) ? OBST_BIRD : OBST_LARGE;
    endfunction

endpackage

// File: rtl/obstacle_gap_calc.sv
// obstacle_gap_calc: gap = GAP_MIN + rnd_hi*GAP_STEP - speed_level*SPEED_STEP, floored at GAP_FLOOR
//   rnd_hi       in  3      upper LFSR bits selecting the random part of the gap
//   speed_level  in  3      difficulty, shortens the gap
//   gap          out GAP_W  gap length in frames
module obstacle_gap_calc
    import dino_pkg::*;
#(
    parameter int GAP_W      = DEF_GAP_W,
    parameter int GAP_MIN    = DEF_GAP_MIN,
    parameter int GAP_STEP   = DEF_GAP_STEP,
    parameter int SPEED_STEP = DEF_SPEED_STEP,
    parameter int GAP_FLOOR  = DEF_GAP_FLOOR
) (
    input  logic [2:0]       rnd_hi,
    input  logic [2:0]       speed_level,
    output logic [GAP_W-1:0] gap
);

    localparam logic signed [GAP_W+1:0] MIN_S   = (GAP_W+2)'(GAP_MIN);
    localparam logic signed [GAP_W+1:0] STEP_S  = (GAP_W+2)'(GAP_STEP);
    localparam logic signed [GAP_W+1:0] SPD_S   = (GAP_W+2)'(SPEED_STEP);
    localparam logic signed [GAP_W+1:0] FLOOR_S = (GAP_W+2)'(GAP_FLOOR);

    logic signed [GAP_W+1:0] rnd_s, spd_s, raw;

    // two extra bits keep the subtraction sign-safe before flooring
    assign rnd_s = $signed({{(GAP_W-1){1'b0}}, rnd_hi});
    assign spd_s = $signed({{(GAP_W-1){1'b0}}, speed_level});
    assign raw   = MIN_S + rnd_s * STEP_S - spd_s * SPD_S;
    assign gap   = raw < FLOOR_S ? FLOOR_S[GAP_W-1:0] : raw[GAP_W-1:0];

endmodule

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: steps the LFSR, draws gap/type, counts frames and requests obstacle spawns
//   clk          in   1      system clock
//   rst_n        in   1      asynchronous active-low reset
//   run          in   1      game running; low forces IDLE
//   clear        in   1      synchronous clear of active_cnt
//   frame_tick   in   1      one pulse per video frame
//   speed_level  in   3      difficulty 0..7
//   rnd          in   5      LFSR value
//   rng_step     out  1      one-cycle LFSR advance request
//   spawn_req    out  1      spawn request, held until spawn_ack
//   spawn_ack    in   1      obstacle engine accepted the spawn
//   spawn_type   out  2      obstacle kind for the pending spawn
//   obst_done    in   1      an obstacle left the screen
//   active_cnt   out  2      obstacles on screen
//   busy         out  1      scheduler not idle
module obstacle_scheduler
    import dino_pkg::*;
#(
    parameter int GAP_W      = DEF_GAP_W,
    parameter int GAP_MIN    = DEF_GAP_MIN,
    parameter int GAP_STEP   = DEF_GAP_STEP,
    parameter int SPEED_STEP = DEF_SPEED_STEP,
    parameter int GAP_FLOOR  = DEF_GAP_FLOOR,
    parameter int MAX_ACTIVE = DEF_MAX_ACTIVE,
    parameter int BIRD_LEVEL = DEF_BIRD_LEVEL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clear,
    input  logic       frame_tick,
    input  logic [2:0] speed_level,
    input  logic [4:0] rnd,
    output logic       rng_step,
    output logic       spawn_req,
    input  logic       spawn_ack,
    output logic [1:0] spawn_type,
    input  logic       obst_done,
    output logic [1:0] active_cnt,
    output logic       busy
);

    state_t           state;
    obst_t            type_q;
    logic [GAP_W-1:0] gap_cnt, gap;
    logic [1:0]       cnt_next;
    logic             inc, dec, room;

    obstacle_gap_calc #(
        .GAP_W(GAP_W),
        .GAP_MIN(GAP_MIN),
        .GAP_STEP(GAP_STEP),
        .SPEED_STEP(SPEED_STEP),
        .GAP_FLOOR(GAP_FLOOR)
    ) u_gap (
        .rnd_hi(rnd[4:2]),
        .speed_level(speed_level),
        .gap(gap)
    );

    assign inc = state == SPAWN && spawn_ack;
    assign dec = obst_done && active_cnt != 2'd0;
    // a departure in the same cycle frees a slot, so it already counts as room
    assign room = active_cnt < 2'(MAX_ACTIVE) || dec;
    assign busy = state != IDLE;
    assign spawn_type = type_q;

    always_comb
        cnt_next = clear ? 2'd0 :
                   (inc && !dec && active_cnt != 2'(MAX_ACTIVE)) ? active_cnt + 2'd1 :
                   (dec && !inc) ? active_cnt - 2'd1 : active_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            type_q     <= OBST_SMALL;
            gap_cnt    <= '0;
            rng_step   <= 1'b0;
            spawn_req  <= 1'b0;
            active_cnt <= 2'd0;
        end else begin
            active_cnt <= cnt_next;
            if (!run) begin
                state     <= IDLE;
                gap_cnt   <= '0;
                rng_step  <= 1'b0;
                spawn_req <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= STEP;
                        rng_step <= 1'b1;
                    end
                    STEP: begin
                        state    <= DRAW;
                        rng_step <= 1'b0;
                    end
                    DRAW: begin
                        state   <= WAIT;
                        gap_cnt <= gap;
                        type_q  <= obst_map(rnd[1:0], speed_level >= 3'(BIRD_LEVEL));
                    end
                    WAIT: if (frame_tick) begin
                        gap_cnt <= gap_cnt - 1'b1;
                        if (gap_cnt == GAP_W'(1)) begin
                            state     <= room ? SPAWN : HOLD;
                            spawn_req <= room;
                        end
                    end
                    HOLD: if (room) begin
                        state     <= SPAWN;
                        spawn_req <= 1'b1;
                    end
                    SPAWN: if (spawn_ack) begin
                        state     <= STEP;
                        spawn_req <= 1'b0;
                        rng_step  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: directed checks of gap timing, type map, occupancy cap, run drop and reset
module tb_obstacle_scheduler;

    logic       clk = 1'b0, rst_n = 1'b0, run = 1'b0, clear = 1'b0;
    logic       frame_tick = 1'b0, spawn_ack = 1'b0, obst_done = 1'b0;
    logic [2:0] speed_level = 3'd0;
    logic [4:0] rnd = 5'd0;
    logic       rng_step, spawn_req, busy;
    logic [1:0] spawn_type, active_cnt;
    logic       early, last;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    obstacle_scheduler dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .clear(clear),
        .frame_tick(frame_tick),
        .speed_level(speed_level),
        .rnd(rnd),
        .rng_step(rng_step),
        .spawn_req(spawn_req),
        .spawn_ack(spawn_ack),
        .spawn_type(spawn_type),
        .obst_done(obst_done),
        .active_cnt(active_cnt),
        .busy(busy)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // n frame ticks spaced two cycles apart; early = req seen before the n-th tick, last = req after it
    task automatic ticks(input int n, output logic e, output logic l);
        e = 1'b0;
        l = 1'b0;
        for (int i = 1; i <= n; i++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            if (i < n && spawn_req) e = 1'b1;
            l = spawn_req;
            cyc();
        end
    endtask

    task automatic ack_cycle(input logic [4:0] r, input logic [2:0] s, input logic with_done);
        rnd = r;
        speed_level = s;
        spawn_ack = 1'b1;
        obst_done = with_done;
        cyc();
        spawn_ack = 1'b0;
        obst_done = 1'b0;
    endtask

    task automatic test_reset;
        cyc();
        cyc();
        checks++; if (rng_step !== 1'b0) begin errors++; $display("FAIL reset_rng_step got %b exp 0", rng_step); end
        checks++; if (spawn_req !== 1'b0) begin errors++; $display("FAIL reset_spawn_req got %b exp 0", spawn_req); end
        checks++; if (spawn_type !== 2'b00) begin errors++; $display("FAIL reset_spawn_type got %b exp 00", spawn_type); end
        checks++; if (active_cnt !== 2'd0) begin errors++; $display("FAIL reset_active_cnt got %0d exp 0", active_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic;
        rnd = 5'b10110;
        speed_level = 3'd0;
        run = 1'b1;
        cyc();
        checks++; if (rng_step !== 1'b1) begin errors++; $display("FAIL basic_step_high got %b exp 1", rng_step); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
        cyc();
        checks++; if (rng_step !== 1'b0) begin errors++; $display("FAIL basic_step_pulse got %b exp 0", rng_step); end
        cyc();
        ticks(88, early, last);
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL basic_early_req got %b exp 0", early); end
        checks++; if (last !== 1'b1) begin errors++; $display("FAIL basic_req_88 got %b exp 1", last); end
        checks++; if (spawn_type !== 2'b01) begin errors++; $display("FAIL basic_type got %b exp 01", spawn_type); end
        checks++; if (active_cnt !== 2'd0) begin errors++; $display("FAIL basic_cnt got %0d exp 0", active_cnt); end
    endtask

    task automatic test_bird;
        ack_cycle(5'b10111, 3'd7, 1'b0);
        checks++; if (spawn_req !== 1'b0) begin errors++; $display("FAIL bird_req_drop got %b exp 0", spawn_req); end
        checks++; if (rng_step !== 1'b1) begin errors++; $display("FAIL bird_restep got %b exp 1", rng_step); end
        checks++; if (active_cnt !== 2'd1) begin errors++; $display("FAIL bird_cnt got %0d exp 1", active_cnt); end
        cyc();
        cyc();
        ticks(60, early, last);
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL bird_early_req got %b exp 0", early); end
        checks++; if (last !== 1'b1) begin errors++; $display("FAIL bird_req_60 got %b exp 1", last); end
        checks++; if (spawn_type !== 2'b10) begin errors++; $display("FAIL bird_type got %b exp 10", spawn_type); end
    endtask

    task automatic test_slow_large;
        ack_cycle(5'b10111, 3'd2, 1'b0);
        checks++; if (active_cnt !== 2'd2) begin errors++; $display("FAIL slow_cnt got %0d exp 2", active_cnt); end
        cyc();
        cyc();
        ticks(40, early, last);
        checks++; if ((early | last) !== 1'b0) begin errors++; $display("FAIL slow_req_40 got %b exp 0", early | last); end
        obst_done = 1'b1;
        cyc();
        obst_done = 1'b0;
        checks++; if (active_cnt !== 2'd1) begin errors++; $display("FAIL slow_done_cnt got %0d exp 1", active_cnt); end
        ticks(40, early, last);
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL slow_early_req got %b exp 0", early); end
        checks++; if (last !== 1'b1) begin errors++; $display("FAIL slow_req_80 got %b exp 1", last); end
        checks++; if (spawn_type !== 2'b01) begin errors++; $display("FAIL slow_type got %b exp 01", spawn_type); end
    endtask

    task automatic test_floor;
        ack_cycle(5'b00000, 3'd7, 1'b0);
        checks++; if (active_cnt !== 2'd2) begin errors++; $display("FAIL floor_cnt got %0d exp 2", active_cnt); end
        cyc();
        cyc();
        ticks(24, early, last);
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL floor_early_req got %b exp 0", early); end
        checks++; if (last !== 1'b1) begin errors++; $display("FAIL floor_req_24 got %b exp 1", last); end
        checks++; if (spawn_type !== 2'b00) begin errors++; $display("FAIL floor_type got %b exp 00", spawn_type); end
    endtask

    task automatic test_hold;
        ack_cycle(5'b10110, 3'd0, 1'b0);
        checks++; if (active_cnt !== 2'd3) begin errors++; $display("FAIL hold_cnt_full got %0d exp 3", active_cnt); end
        cyc();
        cyc();
        ticks(88, early, last);
        cyc();
        cyc();
        checks++; if ((early | last | spawn_req) !== 1'b0) begin errors++; $display("FAIL hold_no_req got %b exp 0", early | last | spawn_req); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy got %b exp 1", busy); end
        obst_done = 1'b1;
        cyc();
        obst_done = 1'b0;
        checks++; if (spawn_req !== 1'b1) begin errors++; $display("FAIL hold_release_req got %b exp 1", spawn_req); end
        checks++; if (active_cnt !== 2'd2) begin errors++; $display("FAIL hold_release_cnt got %0d exp 2", active_cnt); end
        ack_cycle(5'b10110, 3'd0, 1'b0);
        checks++; if (active_cnt !== 2'd3) begin errors++; $display("FAIL hold_ack_cnt got %0d exp 3", active_cnt); end
        checks++; if (spawn_req !== 1'b0) begin errors++; $display("FAIL hold_ack_req got %b exp 0", spawn_req); end
        cyc();
        cyc();
    endtask

    task automatic test_ack_and_done;
        obst_done = 1'b1;
        cyc();
        obst_done = 1'b0;
        ticks(88, early, last);
        checks++; if (last !== 1'b1) begin errors++; $display("FAIL same_req got %b exp 1", last); end
        checks++; if (active_cnt !== 2'd2) begin errors++; $display("FAIL same_pre_cnt got %0d exp 2", active_cnt); end
        ack_cycle(5'b00000, 3'd7, 1'b1);
        checks++; if (active_cnt !== 2'd2) begin errors++; $display("FAIL same_cycle_cnt got %0d exp 2", active_cnt); end
        cyc();
        cyc();
    endtask

    task automatic test_clear;
        obst_done = 1'b1;
        clear = 1'b1;
        cyc();
        obst_done = 1'b0;
        clear = 1'b0;
        checks++; if (active_cnt !== 2'd0) begin errors++; $display("FAIL clear_cnt got %0d exp 0", active_cnt); end
    endtask

    task automatic test_run_drop;
        run = 1'b0;
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_wait_busy got %b exp 0", busy); end
        checks++; if (spawn_req !== 1'b0) begin errors++; $display("FAIL drop_wait_req got %b exp 0", spawn_req); end
        cyc();
        run = 1'b1;
        cyc();
        checks++; if (rng_step !== 1'b1) begin errors++; $display("FAIL drop_restart_step got %b exp 1", rng_step); end
        cyc();
        cyc();
        ticks(24, early, last);
        checks++; if ((early === 1'b0 && last === 1'b1) !== 1'b1) begin errors++; $display("FAIL drop_regap got early=%b last=%b exp early=0 last=1", early, last); end
        run = 1'b0;
        spawn_ack = 1'b1;
        cyc();
        spawn_ack = 1'b0;
        checks++; if (spawn_req !== 1'b0) begin errors++; $display("FAIL drop_spawn_req got %b exp 0", spawn_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_spawn_busy got %b exp 0", busy); end
        checks++; if (active_cnt !== 2'd1) begin errors++; $display("FAIL drop_spawn_cnt got %0d exp 1", active_cnt); end
        checks++; if (rng_step !== 1'b0) begin errors++; $display("FAIL drop_spawn_step got %b exp 0", rng_step); end
    endtask

    task automatic test_reset_mid_wait;
        rnd = 5'b10111;
        speed_level = 3'd7;
        run = 1'b1;
        cyc();
        cyc();
        cyc();
        ticks(10, early, last);
        checks++; if (spawn_type !== 2'b10) begin errors++; $display("FAIL mid_type_before got %b exp 10", spawn_type); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (spawn_type !== 2'b00) begin errors++; $display("FAIL mid_reset_type got %b exp 00", spawn_type); end
        checks++; if (active_cnt !== 2'd0) begin errors++; $display("FAIL mid_reset_cnt got %0d exp 0", active_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b exp 0", busy); end
        checks++; if ((spawn_req | rng_step) !== 1'b0) begin errors++; $display("FAIL mid_reset_req_step got %b exp 0", spawn_req | rng_step); end
        run = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bird();
        test_slow_large();
        test_floor();
        test_hold();
        test_ack_and_done();
        test_clear();
        test_run_drop();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
